// File: rtl/pow_5_pkg.sv
// Shared definitions for the pow_5 request generator: default operand width,
// auto-mode FSM state encoding and the n^5 mod 2^W reference used by the
// optional result checker (enabled by POW5_REQ_GEN_CHECK_EN).
package pow_5_pkg;

  localparam int POW5_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Low bits of a product depend only on low bits of the operands, so a
  // 32-bit computation masked to w bits is exact for any w <= 32.
  function automatic logic [31:0] pow5_mod(input logic [31:0] x, input int unsigned w);
    logic [31:0] p;
    logic [31:0] mask;
    p    = x * x;
    p    = p * p;
    p    = p * x;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return p & mask;
  endfunction

endpackage

// File: rtl/pow_5_req_fifo.sv
// Ordering FIFO: remembers issued operands so each response can be paired
// with the request it answers. Show-ahead read (dout is the oldest entry).
module pow_5_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= ptr_next(wr_q);
      if (pop_ok)  rd_q <= ptr_next(rd_q);
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pow_5_req_gen.sv
// Request generator for a pow_5 responder. Manual mode issues sw on each
// synchronized key press; auto mode runs a wrapping counting sequence with
// one request in flight. Tracks outstanding requests, pairs responses with
// their operands, flags timeouts/spurious responses in err.
// Optional result checker: define POW5_REQ_GEN_CHECK_EN.
module pow_5_req_gen
  import pow_5_pkg::*;
#(
  parameter int W         = POW5_W_DEFAULT,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_req,
  input  logic                       auto_mode,
  input  logic [W-1:0]               sw,
  output logic                       n_vld,
  output logic [W-1:0]               n,
  input  logic                       res_vld,
  input  logic [W-1:0]               res,
  output logic [W-1:0]               last_n,
  output logic [W-1:0]               last_res,
  output logic [$clog2(MAX_OUTST):0] in_flight,
  output logic                       err,
  output logic                       mismatch
);

  localparam int IFW = $clog2(MAX_OUTST) + 1;
  localparam int TW  = $clog2(TIMEOUT + 1) + 1;

  logic           ks1_q, ks2_q, ks3_q;
  logic           press;
  state_t         state_q;
  logic           go_idle;
  logic           issue_man, issue_auto, issue;
  logic [W-1:0]   issue_n;
  logic [W-1:0]   seq_q;
  logic           n_vld_q;
  logic [W-1:0]   n_q;
  logic [W-1:0]   last_n_q, last_res_q;
  logic [IFW-1:0] in_flight_q, in_flight_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           tmo_hit;
  logic           err_q, err_d;
  logic           fifo_full, fifo_empty;
  logic [W-1:0]   fifo_dout;
  logic           res_acc, res_spur;

  // A response is only meaningful when something is outstanding.
  assign res_acc  = res_vld && !fifo_empty;
  assign res_spur = res_vld && fifo_empty;

  assign press      = ks2_q && !ks3_q;
  assign go_idle    = !auto_mode && (in_flight_q == '0);
  assign issue_man  = press && (state_q == ST_IDLE) && !auto_mode && !fifo_full;
  assign issue_auto = (state_q == ST_ISSUE) && !go_idle && !fifo_full;
  assign issue      = issue_man || issue_auto;
  assign issue_n    = issue_auto ? seq_q : sw;

  pow_5_req_fifo #(
    .W     (W),
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (issue_n),
    .pop   (res_acc),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Outstanding count and idle-timeout counter next state.
  always_comb begin
    in_flight_d = in_flight_q;
    if (issue && !res_acc)      in_flight_d = in_flight_q + 1'b1;
    else if (!issue && res_acc) in_flight_d = in_flight_q - 1'b1;

    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (issue || res_vld || (in_flight_q == '0)) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_d   = tmo_q + 1'b1;
      tmo_hit = (tmo_d == TW'(TIMEOUT));
    end

    err_d = err_q || tmo_hit || res_spur;
  end

  // Two-flop synchronizer plus edge-detect flop for the raw key.
  always_ff @(posedge clk) begin
    if (rst) begin
      ks1_q <= 1'b0;
      ks2_q <= 1'b0;
      ks3_q <= 1'b0;
    end else begin
      ks1_q <= key_req;
      ks2_q <= ks1_q;
      ks3_q <= ks2_q;
    end
  end

  // Auto-mode FSM; leaving to IDLE waits for all requests to drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (go_idle) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (auto_mode) state_q <= ST_ISSUE;
        ST_ISSUE: if (!fifo_full) state_q <= ST_WAIT;
        ST_WAIT:  if (res_acc && auto_mode) state_q <= ST_ISSUE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Registered request strobe, sequence counter, response capture, status.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_vld_q     <= 1'b0;
      n_q         <= '0;
      seq_q       <= '0;
      last_n_q    <= '0;
      last_res_q  <= '0;
      in_flight_q <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      n_vld_q     <= issue;
      if (issue)      n_q   <= issue_n;
      if (issue_auto) seq_q <= seq_q + 1'b1;
      if (res_acc) begin
        last_n_q   <= fifo_dout;
        last_res_q <= res;
      end
      in_flight_q <= in_flight_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
    end
  end

`ifdef POW5_REQ_GEN_CHECK_EN
  logic mismatch_q;
  logic chk_bad;

  assign chk_bad = res_acc && (32'(res) != pow5_mod(32'(fifo_dout), W));

  // Sticky flag: a response disagreed with the locally computed n^5.
  always_ff @(posedge clk) begin
    if (rst)          mismatch_q <= 1'b0;
    else if (chk_bad) mismatch_q <= 1'b1;
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign n_vld     = n_vld_q;
  assign n         = n_q;
  assign last_n    = last_n_q;
  assign last_res  = last_res_q;
  assign in_flight = in_flight_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pow_5_req_gen.sv
// Bench for pow_5_req_gen: table of manual operands plus hand-written
// sequences for concurrency, backpressure/timeout, reset and auto mode.
module tb_pow_5_req_gen;

  localparam int W         = 8;
  localparam int MAX_OUTST = 4;
  localparam int TIMEOUT   = 15;
  localparam int IFW       = $clog2(MAX_OUTST) + 1;
`ifdef POW5_REQ_GEN_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           key_req = 1'b0;
  logic           auto_mode = 1'b0;
  logic [W-1:0]   sw = '0;
  logic           n_vld;
  logic [W-1:0]   n;
  logic           res_vld = 1'b0;
  logic [W-1:0]   res = '0;
  logic [W-1:0]   last_n, last_res;
  logic [IFW-1:0] in_flight;
  logic           err, mismatch;

  always #5 clk = ~clk;

  pow_5_req_gen #(
    .W         (W),
    .MAX_OUTST (MAX_OUTST),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_req   (key_req),
    .auto_mode (auto_mode),
    .sw        (sw),
    .n_vld     (n_vld),
    .n         (n),
    .res_vld   (res_vld),
    .res       (res),
    .last_n    (last_n),
    .last_res  (last_res),
    .in_flight (in_flight),
    .err       (err),
    .mismatch  (mismatch)
  );

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] r;
    int           due;
  } rsp_t;

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] res;
  } vec_t;

  rsp_t         sched[$];
  vec_t         vecs[9];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           m_if = 0;
  logic [W-1:0] m_last_n = '0, m_last_res = '0;
  logic         drv_prev = 1'b0;
  logic [W-1:0] drv_n = '0, drv_r = '0;
  bit           resp_on = 0, corrupt = 0, auto_exp_on = 0, chk_lat = 0;
  int           lat = 1;
  logic [W-1:0] auto_seq = '0, sw_exp = '0;
  int           issue_cnt = 0, last_issue_cyc = 0, kc = 0, c0 = 0, c4 = 0;

  function automatic logic [W-1:0] pow5(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = x;
    for (int i = 0; i < 4; i++) r = W'(r * x);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs, update model and scoreboard, drive responder.
  task automatic tick();
    bit           acc;
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_if = 0; m_last_n = '0; m_last_res = '0;
      drv_prev = 1'b0; sched.delete(); res_vld = 1'b0;
      return;
    end
    acc = drv_prev && (m_if > 0);
    if (acc) begin
      m_last_n   = drv_n;
      m_last_res = drv_r;
    end
    if (n_vld === 1'b1) begin
      e = auto_exp_on ? auto_seq : sw_exp;
      if (auto_exp_on) auto_seq = auto_seq + 1'b1;
      chk("n", 32'(n), 32'(e));
      if (chk_lat) chk("press_latency", cyc - kc, 3);
      issue_cnt++;
      last_issue_cyc = cyc;
      if (resp_on) sched.push_back('{n: e, r: (corrupt ? {W{1'b0}} : pow5(e)), due: cyc + lat});
    end
    m_if = m_if + ((n_vld === 1'b1) ? 1 : 0) - (acc ? 1 : 0);
    chk("in_flight", 32'(in_flight), m_if);
    chk("last_n", 32'(last_n), 32'(m_last_n));
    chk("last_res", 32'(last_res), 32'(m_last_res));
    drv_prev = 1'b0;
    res_vld  = 1'b0;
    if (sched.size() > 0 && sched[0].due == cyc) begin
      res_vld  = 1'b1;
      res      = sched[0].r;
      drv_n    = sched[0].n;
      drv_r    = sched[0].r;
      drv_prev = 1'b1;
      void'(sched.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; key_req = 1'b0; auto_mode = 1'b0; res_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic press();
    key_req = 1'b1;
    kc = cyc;
    tick(); tick();
    key_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    vecs[0] = '{sw: 8'd3,   res: 8'd243};
    vecs[1] = '{sw: 8'd2,   res: 8'd32};
    vecs[2] = '{sw: 8'd0,   res: 8'd0};
    vecs[3] = '{sw: 8'd1,   res: 8'd1};
    vecs[4] = '{sw: 8'd4,   res: 8'd0};
    vecs[5] = '{sw: 8'd5,   res: 8'd53};
    vecs[6] = '{sw: 8'd255, res: 8'd255};
    vecs[7] = '{sw: 8'd7,   res: 8'd167};
    vecs[8] = '{sw: 8'd10,  res: 8'd160};

    // Reset state
    do_reset();
    chk("rst_n_vld", 32'(n_vld), 0);
    chk("rst_n", 32'(n), 0);
    chk("rst_last_n", 32'(last_n), 0);
    chk("rst_last_res", 32'(last_res), 0);
    chk("rst_in_flight", 32'(in_flight), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mismatch", 32'(mismatch), 0);

    // Manual table with an ideal one-cycle responder
    resp_on = 1; lat = 1; corrupt = 0; auto_exp_on = 0; chk_lat = 1;
    for (int i = 0; i < 9; i++) begin
      sw = vecs[i].sw; sw_exp = vecs[i].sw;
      c0 = issue_cnt;
      press();
      repeat (3) tick();
      chk("tbl_issues", issue_cnt - c0, 1);
      chk("tbl_last_n", 32'(last_n), 32'(vecs[i].sw));
      chk("tbl_last_res", 32'(last_res), 32'(vecs[i].res));
      chk("tbl_in_flight", 32'(in_flight), 0);
    end
    chk_lat = 0;
    chk("tbl_err", 32'(err), 0);
    chk("tbl_mismatch", 32'(mismatch), 0);

    // Spurious response with nothing outstanding
    sched.push_back('{n: 8'd99, r: 8'd99, due: cyc + 1});
    tick(); tick();
    chk("spur_err", 32'(err), 1);
    chk("spur_last_n", 32'(last_n), 10);
    chk("spur_last_res", 32'(last_res), 160);
    chk("spur_in_flight", 32'(in_flight), 0);

    // Issue and response on the same edge at in_flight=1
    do_reset();
    resp_on = 0;
    sw = 8'd11; sw_exp = 8'd11;
    press();
    chk("simul_pre_if", 32'(in_flight), 1);
    sw = 8'd12; sw_exp = 8'd12;
    key_req = 1'b1;
    kc = cyc;
    sched.push_back('{n: 8'd11, r: pow5(8'd11), due: cyc + 2});
    tick(); tick(); tick();
    chk("simul_n_vld", 32'(n_vld), 1);
    chk("simul_in_flight", 32'(in_flight), 1);
    key_req = 1'b0;
    tick();
    chk("simul_last_n_a", 32'(last_n), 11);
    chk("simul_last_res_a", 32'(last_res), 27);
    sched.push_back('{n: 8'd12, r: pow5(8'd12), due: cyc + 1});
    tick(); tick();
    chk("simul_last_n_b", 32'(last_n), 12);
    chk("simul_last_res_b", 32'(last_res), 0);
    chk("simul_if_end", 32'(in_flight), 0);
    chk("simul_err", 32'(err), 0);

    // Wrong result from responder
    do_reset();
    resp_on = 1; lat = 1; corrupt = 1;
    sw = 8'd2; sw_exp = 8'd2;
    press();
    repeat (2) tick();
    chk("chk_mismatch", 32'(mismatch), 32'(EXP_MM));
    chk("chk_last_n", 32'(last_n), 2);
    chk("chk_last_res", 32'(last_res), 0);
    corrupt = 0;

    // Backpressure and timeout with a silent responder
    do_reset();
    resp_on = 0;
    sw = 8'd9; sw_exp = 8'd9;
    c0 = issue_cnt;
    repeat (6) press();
    chk("bp_issues", issue_cnt - c0, 4);
    chk("bp_in_flight", 32'(in_flight), 4);
    c4 = last_issue_cyc;
    chk("bp_window", 32'(cyc <= c4 + TIMEOUT - 1), 1);
    while (cyc < c4 + TIMEOUT - 1) tick();
    chk("tmo_err_before", 32'(err), 0);
    tick();
    chk("tmo_err_at", 32'(err), 1);

    // Reset mid-operation discards requests; late response is spurious
    do_reset();
    chk("mid_rst_if", 32'(in_flight), 0);
    chk("mid_rst_err", 32'(err), 0);
    sched.push_back('{n: 8'd9, r: pow5(8'd9), due: cyc + 1});
    tick(); tick();
    chk("late_rsp_err", 32'(err), 1);
    chk("late_rsp_if", 32'(in_flight), 0);
    chk("late_rsp_last_n", 32'(last_n), 0);

    // Auto mode, latency-2 responder, key chatter must be ignored
    do_reset();
    resp_on = 1; lat = 2; auto_exp_on = 1; auto_seq = '0;
    sw = 8'd77; sw_exp = 8'd77;
    c0 = issue_cnt;
    auto_mode = 1'b1;
    for (int k = 0; k < 4000 && (issue_cnt - c0) < 260; k++) begin
      key_req = ((cyc % 16) < 4);
      tick();
    end
    auto_mode = 1'b0;
    key_req = 1'b0;
    repeat (10) tick();
    chk("auto_issues", issue_cnt - c0, 260);
    chk("auto_last_n", 32'(last_n), 3);
    chk("auto_last_res", 32'(last_res), 243);
    chk("auto_in_flight", 32'(in_flight), 0);
    chk("auto_err", 32'(err), 0);
    chk("auto_mismatch", 32'(mismatch), 0);
    auto_exp_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
